// File: rtl/imm_pkg.sv
// Shared opcode and format definitions for the registered immediate decoder.
// Optional macro IMM_ZICSR_EN (used by imm_gen_comb) enables CSR-immediate decoding.
package imm_pkg;

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    // Bit positions inside the one-hot format vector
    localparam int FMT_R = 0;
    localparam int FMT_I = 1;
    localparam int FMT_S = 2;
    localparam int FMT_B = 3;
    localparam int FMT_U = 4;
    localparam int FMT_J = 5;
    localparam int FMT_W = 6;

    typedef logic [FMT_W-1:0] fmt_t;

    function automatic fmt_t fmt_onehot(input int idx);
        fmt_t f;
        f = '0;
        f[idx] = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/imm_gen_comb.sv
// Combinational opcode -> format / illegal / sign-extended immediate generator.
// With IMM_ZICSR_EN defined, CSR*I encodings yield the zero-extended uimm field.
module imm_gen_comb
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]      inst,
    output logic [FMT_W-1:0] format,
    output logic             illegal,
    output logic [XLEN-1:0]  immediate
);

    logic [6:0]  opcode;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic [31:0] imm_u;
    logic        unused_funct3;

    assign opcode = inst[6:0];

    // All variants are built as 32-bit signed values, then widened once below
    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};

    assign unused_funct3 = ^inst[14:12];

    always_comb begin
        format    = '0;
        illegal   = 1'b0;
        immediate = '0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                format    = fmt_onehot(FMT_U);
                immediate = XLEN'($signed(imm_u));
            end
            OPC_JAL: begin
                format    = fmt_onehot(FMT_J);
                immediate = XLEN'($signed(imm_j));
            end
            OPC_BRANCH: begin
                format    = fmt_onehot(FMT_B);
                immediate = XLEN'($signed(imm_b));
            end
            OPC_STORE: begin
                format    = fmt_onehot(FMT_S);
                immediate = XLEN'($signed(imm_s));
            end
            OPC_OP: begin
                format    = fmt_onehot(FMT_R);
            end
            OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_MISCMEM, OPC_SYSTEM: begin
                format    = fmt_onehot(FMT_I);
                immediate = XLEN'($signed(imm_i));
`ifdef IMM_ZICSR_EN
                if (opcode == OPC_SYSTEM && inst[14]) begin
                    immediate = XLEN'({27'b0, inst[19:15]});
                end
`endif
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_decode_buf.sv
// Registered immediate decoder: imm_gen_comb feeding a 2-entry ready/valid FIFO.
// Optional macro IMM_ZICSR_EN is forwarded to imm_gen_comb (CSR*I uimm decoding).
module imm_decode_buf
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_inst,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_immediate,
    output logic [FMT_W-1:0] o_format,
    output logic             o_illegal,
    output logic [TAG_W-1:0] o_tag
);

    localparam int DEPTH = 2;

    logic [FMT_W-1:0] dec_format;
    logic             dec_illegal;
    logic [XLEN-1:0]  dec_immediate;

    imm_gen_comb #(
        .XLEN(XLEN)
    ) u_gen (
        .inst      (i_inst),
        .format    (dec_format),
        .illegal   (dec_illegal),
        .immediate (dec_immediate)
    );

    logic [XLEN-1:0]  imm_mem [DEPTH];
    logic [FMT_W-1:0] fmt_mem [DEPTH];
    logic             ill_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem [DEPTH];

    logic [1:0] count_reg, count_next;
    logic       wr_ptr_reg, wr_ptr_next;
    logic       rd_ptr_reg, rd_ptr_next;
    logic       valid_reg;
    logic       ready_reg;
    logic       push;
    logic       pop;
    logic [DEPTH-1:0] wr_en;

    // Handshakes only look at registered flags, so no ready path is combinational
    assign push = i_valid & ready_reg & ~i_flush;
    assign pop  = valid_reg & i_ready & ~i_flush;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (wr_ptr_reg == 1'(gi));
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                imm_mem[i] <= '0;
                fmt_mem[i] <= '0;
                ill_mem[i] <= 1'b0;
                tag_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) begin
                    imm_mem[i] <= dec_immediate;
                    fmt_mem[i] <= dec_format;
                    ill_mem[i] <= dec_illegal;
                    tag_mem[i] <= i_tag;
                end
            end
        end
    end

    always_comb begin
        count_next  = count_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (i_flush) begin
            count_next  = 2'd0;
            wr_ptr_next = 1'b0;
            rd_ptr_next = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_next = ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_next = ~rd_ptr_reg;
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + 2'd1;
                2'b01:   count_next = count_reg - 2'd1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_reg  <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            valid_reg  <= 1'b0;
            ready_reg  <= 1'b1;
        end else begin
            count_reg  <= count_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            valid_reg  <= (count_next != 2'd0);
            ready_reg  <= (count_next < 2'd2);
        end
    end

    assign o_valid     = valid_reg;
    assign o_ready     = ready_reg;
    assign o_immediate = imm_mem[rd_ptr_reg];
    assign o_format    = fmt_mem[rd_ptr_reg];
    assign o_illegal   = ill_mem[rd_ptr_reg];
    assign o_tag       = tag_mem[rd_ptr_reg];

endmodule
